// File: rtl/simple_single_cpu.sv
`default_nettype none
// ============================================================================
// Module     : simple_single_cpu
// Description: Single-cycle 32-bit MIPS-subset core. Fetch, decode, execute,
//              memory access and write-back all finish within one clock.
//              Sub-instances PC, IM, RF and DM hold the architectural state.
// Revision   : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Program counter register
// ----------------------------------------------------------------------------
module sscpu_pc (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] pc_in_i,
    output logic [31:0] pc_out_o
);
    logic [31:0] pc_q;

    // Advance to the next PC every cycle; async reset restarts at address 0
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_in_i;
        end
    end

    assign pc_out_o = pc_q;
endmodule

// ----------------------------------------------------------------------------
// Instruction memory: 128 words, contents loaded from outside the design
// ----------------------------------------------------------------------------
module sscpu_imem (
    input  logic [6:0]  addr_i,
    output logic [31:0] instr_o
);
    logic [31:0] Instr_Mem [0:127];

    assign instr_o = Instr_Mem[addr_i];
endmodule

// ----------------------------------------------------------------------------
// Register file: 32 x 32, two combinational read ports, one write port
// ----------------------------------------------------------------------------
module sscpu_regfile (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    input  logic        we_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i
);
    localparam logic [31:0] SP_RESET = 32'd128;

    logic [31:0] Reg_File [0:31];

    // Write port; $0 is never written so it reads back as zero forever
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                Reg_File[i] <= (i == 29) ? SP_RESET : 32'd0;
            end
        end else if (we_i && (rd_addr_i != 5'd0)) begin
            Reg_File[rd_addr_i] <= rd_data_i;
        end
    end

    assign rs_data_o = Reg_File[rs_addr_i];
    assign rt_data_o = Reg_File[rt_addr_i];
endmodule

// ----------------------------------------------------------------------------
// Data memory: 32 words (128 bytes), word access only, address wraps
// ----------------------------------------------------------------------------
module sscpu_dmem (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [31:0] rdata_o
);
    logic [31:0] memory [0:31];

    // Store port; whole memory clears on reset
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                memory[i] <= 32'd0;
            end
        end else if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = memory[addr_i];
endmodule

// ----------------------------------------------------------------------------
// Top: decode, ALU, next-PC and write-back selection
// ----------------------------------------------------------------------------
module simple_single_cpu (
    input  logic clk_i,
    input  logic rst_n
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNEZ  = 6'b000101;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MUL   = 6'b011000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [4:0] RA_REG   = 5'd31;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] dm_rdata;
    logic [31:0] sext_imm;
    logic [31:0] mem_addr;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] mul_res;
    logic [31:0] sllv_res;
    logic [31:0] srlv_res;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [4:0]  rd_a;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;

    logic [31:0] next_pc_d;
    logic [31:0] wr_data_d;
    logic [4:0]  wr_addr_d;
    logic        rf_we_d;
    logic        dm_we_d;

    sscpu_pc PC (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .pc_in_i  (next_pc_d),
        .pc_out_o (pc)
    );

    sscpu_imem IM (
        .addr_i  (pc[8:2]),
        .instr_o (instr)
    );

    sscpu_regfile RF (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .rs_addr_i (rs_a),
        .rt_addr_i (rt_a),
        .rs_data_o (rs_val),
        .rt_data_o (rt_val),
        .we_i      (rf_we_d),
        .rd_addr_i (wr_addr_d),
        .rd_data_i (wr_data_d)
    );

    sscpu_dmem DM (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .addr_i  (mem_addr[6:2]),
        .wdata_i (rt_val),
        .we_i    (dm_we_d),
        .rdata_o (dm_rdata)
    );

    // Instruction field split
    assign opcode = instr[31:26];
    assign rs_a   = instr[25:21];
    assign rt_a   = instr[20:16];
    assign rd_a   = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];

    assign pc4        = pc + 32'd4;
    assign sext_imm   = {{16{imm[15]}}, imm};
    // Shared adder: load/store effective address and addi result
    assign mem_addr   = rs_val + sext_imm;
    assign br_target  = pc4 + {sext_imm[29:0], 2'b00};
    assign jmp_target = {pc4[31:28], target, 2'b00};
    assign mul_res    = rs_val * rt_val;
    // Variable shifts look at the whole rs value, so 32 and above flush to 0
    assign sllv_res   = (rs_val > 32'd31) ? 32'd0 : (rt_val << rs_val[4:0]);
    assign srlv_res   = (rs_val > 32'd31) ? 32'd0 : (rt_val >> rs_val[4:0]);

    // Decode and execute: next PC, write-back target/data and store enable
    always_comb begin
        next_pc_d = pc4;
        wr_data_d = 32'd0;
        wr_addr_d = rd_a;
        rf_we_d   = 1'b0;
        dm_we_d   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rf_we_d = 1'b1;
                case (funct)
                    FN_ADD:  wr_data_d = rs_val + rt_val;
                    FN_SUB:  wr_data_d = rs_val - rt_val;
                    FN_AND:  wr_data_d = rs_val & rt_val;
                    FN_OR:   wr_data_d = rs_val | rt_val;
                    FN_SLT:  wr_data_d = (rs_val < rt_val) ? 32'd1 : 32'd0;
                    FN_SLLV: wr_data_d = sllv_res;
                    FN_SRLV: wr_data_d = srlv_res;
                    FN_SLL:  wr_data_d = rt_val << shamt;
                    FN_SRL:  wr_data_d = rt_val >> shamt;
                    FN_MUL:  wr_data_d = mul_res;
                    FN_JR: begin
                        rf_we_d   = 1'b0;
                        next_pc_d = rs_val;
                    end
                    default: rf_we_d = 1'b0;
                endcase
            end
            OP_ADDI: begin
                rf_we_d   = 1'b1;
                wr_addr_d = rt_a;
                wr_data_d = mem_addr;
            end
            OP_ORI: begin
                rf_we_d   = 1'b1;
                wr_addr_d = rt_a;
                wr_data_d = rs_val | {16'd0, imm};
            end
            OP_LUI: begin
                // Immediate lands in the low half on purpose
                rf_we_d   = 1'b1;
                wr_addr_d = rt_a;
                wr_data_d = {16'd0, imm};
            end
            OP_LW: begin
                rf_we_d   = 1'b1;
                wr_addr_d = rt_a;
                wr_data_d = dm_rdata;
            end
            OP_SW:   dm_we_d = 1'b1;
            OP_BEQ:  if (rs_val == rt_val) next_pc_d = br_target;
            OP_BGT:  if (rs_val > rt_val)  next_pc_d = br_target;
            OP_BNEZ: if (rs_val != 32'd0)  next_pc_d = br_target;
            // Unsigned compare against zero is always true
            OP_BGEZ: next_pc_d = br_target;
            OP_J:    next_pc_d = jmp_target;
            OP_JAL: begin
                next_pc_d = jmp_target;
                rf_we_d   = 1'b1;
                wr_addr_d = RA_REG;
                wr_data_d = pc4;
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_simple_single_cpu.sv
`default_nettype none
// ============================================================================
// Module     : tb_simple_single_cpu
// Description: Directed bench for simple_single_cpu. Loads small programs into
//              IM, runs them and compares architectural state to hand-computed
//              values held in a check table.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_simple_single_cpu;

    localparam int KIND_REG = 0;
    localparam int KIND_MEM = 1;
    localparam int KIND_PC  = 2;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    logic clk_i;
    logic rst_n;

    int n_tests;
    int n_fail;

    chk_t tab[$];

    simple_single_cpu dut (
        .clk_i (clk_i),
        .rst_n (rst_n)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tg);
        return {op, tg};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int kind, input int idx);
        logic [31:0] v;
        case (kind)
            KIND_REG: v = dut.RF.Reg_File[idx];
            KIND_MEM: v = dut.DM.memory[idx];
            default:  v = dut.PC.pc_out_o;
        endcase
        return v;
    endfunction

    task automatic add(input string name, input int kind, input int idx, input logic [31:0] exp);
        chk_t c;
        c.name = name; c.kind = kind; c.idx = idx; c.exp = exp;
        tab.push_back(c);
    endtask

    task automatic run_table();
        foreach (tab[i]) check(tab[i].name, probe(tab[i].kind, tab[i].idx), tab[i].exp);
        tab.delete();
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic clear_im();
        for (int i = 0; i < 128; i++) dut.IM.Instr_Mem[i] = 32'd0;
    endtask

    // Whole-state reset checks: counts nonconforming regs / DM words
    task automatic check_reset_state(input string tag);
        int bad_rf;
        int bad_dm;
        bad_rf = 0;
        bad_dm = 0;
        for (int i = 0; i < 32; i++) begin
            if (dut.RF.Reg_File[i] !== ((i == 29) ? 32'd128 : 32'd0)) bad_rf++;
            if (dut.DM.memory[i] !== 32'd0) bad_dm++;
        end
        check({tag, "_pc"}, dut.PC.pc_out_o, 32'd0);
        check({tag, "_rf_bad_count"}, 32'(bad_rf), 32'd0);
        check({tag, "_dm_bad_count"}, 32'(bad_dm), 32'd0);
    endtask

    logic [31:0] pc_seq [16] = '{32'h04, 32'h08, 32'h0C, 32'h14, 32'h1C, 32'h20,
                                 32'h40, 32'h44, 32'h48, 32'h44, 32'h48, 32'h4C,
                                 32'h54, 32'h24, 32'h28, 32'h00};

    initial begin
        int other_dm;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;

        // ---------------- program A: ALU, shifts, memory ----------------
        clear_im();
        dut.IM.Instr_Mem[0]  = enc_i(6'b001000, 5'd1, 5'd0, 16'd5);          // addi $1,$0,5
        dut.IM.Instr_Mem[1]  = enc_i(6'b001000, 5'd2, 5'd0, 16'hFFFD);       // addi $2,$0,-3
        dut.IM.Instr_Mem[2]  = enc_r(6'b100000, 5'd3, 5'd1, 5'd2, 5'd0);     // add $3,$1,$2
        dut.IM.Instr_Mem[3]  = enc_r(6'b100010, 5'd4, 5'd2, 5'd1, 5'd0);     // sub $4,$2,$1
        dut.IM.Instr_Mem[4]  = enc_r(6'b101010, 5'd5, 5'd1, 5'd2, 5'd0);     // slt $5,$1,$2
        dut.IM.Instr_Mem[5]  = enc_r(6'b011000, 5'd6, 5'd1, 5'd1, 5'd0);     // mul $6,$1,$1
        dut.IM.Instr_Mem[6]  = enc_i(6'b001101, 5'd7, 5'd0, 16'hF0F0);       // ori $7,$0,0xF0F0
        dut.IM.Instr_Mem[7]  = enc_r(6'b000000, 5'd8, 5'd0, 5'd7, 5'd4);     // sll $8,$7,4
        dut.IM.Instr_Mem[8]  = enc_r(6'b000010, 5'd9, 5'd0, 5'd8, 5'd8);     // srl $9,$8,8
        dut.IM.Instr_Mem[9]  = enc_i(6'b001111, 5'd10, 5'd0, 16'h1234);      // lui $10,0x1234
        dut.IM.Instr_Mem[10] = enc_i(6'b101011, 5'd1, 5'd29, 16'hFFFC);      // sw $1,-4($29)
        dut.IM.Instr_Mem[11] = enc_i(6'b100011, 5'd11, 5'd29, 16'hFFFC);     // lw $11,-4($29)
        dut.IM.Instr_Mem[12] = enc_r(6'b000100, 5'd12, 5'd1, 5'd7, 5'd0);    // sllv $12,$7,$1
        dut.IM.Instr_Mem[13] = enc_r(6'b000110, 5'd13, 5'd1, 5'd7, 5'd0);    // srlv $13,$7,$1
        dut.IM.Instr_Mem[14] = enc_i(6'b001000, 5'd14, 5'd0, 16'd40);        // addi $14,$0,40
        dut.IM.Instr_Mem[15] = enc_r(6'b000100, 5'd15, 5'd14, 5'd7, 5'd0);   // sllv $15,$7,$14
        dut.IM.Instr_Mem[16] = enc_i(6'b001000, 5'd0, 5'd0, 16'd7);          // addi $0,$0,7
        dut.IM.Instr_Mem[17] = enc_r(6'b100000, 5'd16, 5'd1, 5'd1, 5'd0);    // add $16,$1,$1
        dut.IM.Instr_Mem[18] = enc_r(6'b101010, 5'd18, 5'd2, 5'd1, 5'd0);    // slt $18,$2,$1
        dut.IM.Instr_Mem[19] = enc_r(6'b000110, 5'd19, 5'd14, 5'd7, 5'd0);   // srlv $19,$7,$14
        dut.IM.Instr_Mem[20] = 32'hFC00_0000;                                // undefined opcode
        dut.IM.Instr_Mem[21] = enc_r(6'b111111, 5'd17, 5'd1, 5'd1, 5'd0);    // undefined funct

        step();
        step();
        check_reset_state("reset");
        rst_n = 1'b1;
        step();
        check("first_pc_after_reset", dut.PC.pc_out_o, 32'd4);
        for (int i = 1; i < 22; i++) step();

        add("A_$0",   KIND_REG, 0,  32'h0000_0000);
        add("A_$1",   KIND_REG, 1,  32'h0000_0005);
        add("A_$2",   KIND_REG, 2,  32'hFFFF_FFFD);
        add("A_add",  KIND_REG, 3,  32'h0000_0002);
        add("A_sub",  KIND_REG, 4,  32'hFFFF_FFF8);
        add("A_slt",  KIND_REG, 5,  32'h0000_0001);
        add("A_mul",  KIND_REG, 6,  32'h0000_0019);
        add("A_ori",  KIND_REG, 7,  32'h0000_F0F0);
        add("A_sll",  KIND_REG, 8,  32'h000F_0F00);
        add("A_srl",  KIND_REG, 9,  32'h0000_0F0F);
        add("A_lui",  KIND_REG, 10, 32'h0000_1234);
        add("A_lw",   KIND_REG, 11, 32'h0000_0005);
        add("A_sllv", KIND_REG, 12, 32'h001E_1E00);
        add("A_srlv", KIND_REG, 13, 32'h0000_0787);
        add("A_sllv_big", KIND_REG, 15, 32'h0000_0000);
        add("A_add16",    KIND_REG, 16, 32'h0000_000A);
        add("A_nop_funct", KIND_REG, 17, 32'h0000_0000);
        add("A_slt_false", KIND_REG, 18, 32'h0000_0000);
        add("A_srlv_big", KIND_REG, 19, 32'h0000_0000);
        add("A_sp",   KIND_REG, 29, 32'h0000_0080);
        add("A_dm31", KIND_MEM, 31, 32'h0000_0005);
        add("A_pc",   KIND_PC,  0,  32'h0000_0058);
        run_table();

        other_dm = 0;
        for (int i = 0; i < 31; i++) if (dut.DM.memory[i] !== 32'd0) other_dm++;
        check("A_other_dm_words_changed", 32'(other_dm), 32'd0);

        // Async reset away from any clock edge clears state immediately
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async_reset_A");

        // ---------------- program B: branches and jumps ----------------
        @(negedge clk_i);
        clear_im();
        dut.IM.Instr_Mem[0]  = enc_i(6'b001000, 5'd1, 5'd0, 16'd5);          // addi $1,$0,5
        dut.IM.Instr_Mem[1]  = enc_i(6'b001000, 5'd2, 5'd0, 16'hFFFD);       // addi $2,$0,-3
        dut.IM.Instr_Mem[2]  = enc_i(6'b000100, 5'd2, 5'd1, 16'd7);          // beq $1,$2,7 (not taken)
        dut.IM.Instr_Mem[3]  = enc_i(6'b000100, 5'd1, 5'd1, 16'd1);          // beq $1,$1,1 (taken)
        dut.IM.Instr_Mem[4]  = enc_i(6'b001000, 5'd20, 5'd0, 16'd99);        // skipped
        dut.IM.Instr_Mem[5]  = enc_i(6'b000111, 5'd1, 5'd2, 16'd1);          // bgt $2,$1,1
        dut.IM.Instr_Mem[6]  = enc_i(6'b001000, 5'd20, 5'd0, 16'd99);        // skipped
        dut.IM.Instr_Mem[7]  = enc_i(6'b000101, 5'd0, 5'd0, 16'd5);          // bnez $0,5
        dut.IM.Instr_Mem[8]  = enc_j(6'b000011, 26'h10);                     // jal 0x40
        dut.IM.Instr_Mem[9]  = enc_i(6'b001000, 5'd6, 5'd6, 16'd1);          // 0x24 addi $6,$6,1
        dut.IM.Instr_Mem[10] = enc_j(6'b000010, 26'h0);                      // 0x28 j 0
        dut.IM.Instr_Mem[16] = enc_i(6'b001000, 5'd3, 5'd3, 16'd1);          // 0x40 addi $3,$3,1
        dut.IM.Instr_Mem[17] = enc_i(6'b001000, 5'd4, 5'd4, 16'd1);          // 0x44 addi $4,$4,1
        dut.IM.Instr_Mem[18] = enc_i(6'b000100, 5'd4, 5'd3, 16'hFFFE);       // 0x48 beq $3,$4,-2
        dut.IM.Instr_Mem[19] = enc_i(6'b000001, 5'd0, 5'd0, 16'd1);          // 0x4C bgez $0,1
        dut.IM.Instr_Mem[20] = enc_i(6'b001000, 5'd20, 5'd0, 16'd99);        // skipped
        dut.IM.Instr_Mem[21] = enc_r(6'b001000, 5'd0, 5'd31, 5'd0, 5'd0);    // 0x54 jr $31
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("B_pc_step%0d", i + 1), dut.PC.pc_out_o, pc_seq[i]);
        end

        add("B_ra",       KIND_REG, 31, 32'h0000_0024);
        add("B_loop_3",   KIND_REG, 3,  32'h0000_0001);
        add("B_loop_4",   KIND_REG, 4,  32'h0000_0002);
        add("B_after_jr", KIND_REG, 6,  32'h0000_0001);
        add("B_skipped",  KIND_REG, 20, 32'h0000_0000);
        run_table();

        // Mid-program reset, then restart from address 0
        step();
        step();
        step();
        check("B_pc_rerun", dut.PC.pc_out_o, 32'h0000_000C);
        #2 rst_n = 1'b0;
        #1;
        check("B_midreset_pc", dut.PC.pc_out_o, 32'd0);
        check("B_midreset_$1", dut.RF.Reg_File[1], 32'd0);
        check("B_midreset_$31", dut.RF.Reg_File[31], 32'd0);
        check("B_midreset_sp", dut.RF.Reg_File[29], 32'd128);
        step();
        check("B_held_in_reset_pc", dut.PC.pc_out_o, 32'd0);
        rst_n = 1'b1;
        step();
        check("B_restart_pc", dut.PC.pc_out_o, 32'd4);
        check("B_restart_$1", dut.RF.Reg_File[1], 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
